// File: rtl/addsub_pipe.sv
// Pipelined adder/subtractor: WIDTH-bit operation split into CHUNK-bit slices, one slice per stage.
// Optional ADDSUB_SATURATE_EN clamps the result to the signed limit on overflow.
module addsub_pipe #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int STAGES = WIDTH / CHUNK;
   localparam int LAST   = STAGES - 1;

   logic [WIDTH-1:0]             bp;
   logic                         c0;
   logic                         adv;
   logic                         a_msb;
   logic                         b_msb;
   logic [WIDTH-1:0]             raw;
   logic [STAGES-1:0]            vld_q, vld_d;
   logic [STAGES-1:0]            cy_q, cy_d;
   logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
   logic [STAGES-1:0][WIDTH-1:0] bp_q, bp_d;
   logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0]             res_q, res_d;
   logic                         ovf_q, ovf_d;
   logic                         zero_q, zero_d;
   logic                         neg_q, neg_d;
   logic                         unused_pipe;

   always_comb begin
      bp = op[0] ? ~b : b;
      case (op)
         2'b00:   c0 = 1'b0;
         2'b01:   c0 = 1'b1;
         default: c0 = cin;
      endcase
   end

   // Each stage passes full-width operands and partial sum; it only fills in its own slice.
   always_comb begin : stage_logic
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] s_in;
      logic             c_in;
      logic             v_in;
      logic [CHUNK:0]   slice;
      int               kp;
      a_d   = '0;
      bp_d  = '0;
      sum_d = '0;
      cy_d  = '0;
      vld_d = '0;
      a_in  = '0;
      b_in  = '0;
      s_in  = '0;
      c_in  = 1'b0;
      v_in  = 1'b0;
      slice = '0;
      kp    = 0;
      for (int k = 0; k < STAGES; k++) begin
         kp = (k == 0) ? 0 : k - 1;
         if (k == 0) begin
            a_in = a;
            b_in = bp;
            s_in = '0;
            c_in = c0;
            v_in = in_valid;
         end else begin
            a_in = a_q[kp];
            b_in = bp_q[kp];
            s_in = sum_q[kp];
            c_in = cy_q[kp];
            v_in = vld_q[kp];
         end
         slice = {1'b0, a_in[k*CHUNK +: CHUNK]} + {1'b0, b_in[k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, c_in};
         a_d[k]   = a_in;
         bp_d[k]  = b_in;
         sum_d[k] = s_in;
         sum_d[k][k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
         cy_d[k]  = slice[CHUNK];
         vld_d[k] = v_in;
      end
      a_msb = a_in[WIDTH-1];
      b_msb = b_in[WIDTH-1];
   end

   always_comb begin
      raw   = sum_d[LAST];
      ovf_d = (a_msb == b_msb) && (raw[WIDTH-1] != a_msb);
`ifdef ADDSUB_SATURATE_EN
      if (ovf_d) begin
         res_d = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         res_d = raw;
      end
`else
      res_d = raw;
`endif
      zero_d = (res_d == '0);
      neg_d  = res_d[WIDTH-1];
   end

   assign adv = !vld_q[LAST] || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         cy_q   <= '0;
         a_q    <= '0;
         bp_q   <= '0;
         sum_q  <= '0;
         res_q  <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
      end else if (adv) begin
         vld_q  <= vld_d;
         cy_q   <= cy_d;
         a_q    <= a_d;
         bp_q   <= bp_d;
         sum_q  <= sum_d;
         res_q  <= res_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
         neg_q  <= neg_d;
      end
   end

   assign in_ready  = adv;
   assign out_valid = vld_q[LAST];
   assign result    = res_q;
   assign carry_out = cy_q[LAST];
   assign overflow  = ovf_q;
   assign zero      = zero_q;
   assign negative  = neg_q;

   // Already-consumed operand slices and the last raw sum are dead after their stage.
   assign unused_pipe = ^{a_q, bp_q, sum_q};

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: vector table, stream/stall/reset sequences, random vs. arithmetic model.
module tb_addsub_pipe;
   localparam int W = 8;
   localparam int C = 4;
   localparam int S = W / C;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         cin = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready, out_valid, carry_out, overflow, zero, negative;
   logic [W-1:0] result;

   addsub_pipe #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero),
      .negative(negative)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] res;
      logic         co;
      logic         ov;
      logic         z;
      logic         n;
   } vec_t;

   typedef struct {
      logic [W-1:0] res;
      logic         co;
      logic         ov;
      logic         z;
      logic         n;
   } exp_t;

   vec_t vecs[8];
   exp_t q[$];
   exp_t held;
   int   n_cmp = 0;
   int   n_fail = 0;
   logic stalled = 1'b0;
   logic last_acc, last_emit, last_in_ready;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] ai,
                                  input logic [W-1:0] bi, input logic ci);
      exp_t e;
      int lim, ua, ub, c, full, sa, sb, exact, res;
      lim   = 1 << W;
      ua    = int'(ai);
      ub    = o[0] ? (lim - 1 - int'(bi)) : int'(bi);
      c     = (o == 2'b00) ? 0 : (o == 2'b01) ? 1 : int'(ci);
      full  = ua + ub + c;
      sa    = (ua >= lim / 2) ? ua - lim : ua;
      sb    = (ub >= lim / 2) ? ub - lim : ub;
      exact = sa + sb + c;
      e.co  = (full >= lim);
      e.ov  = (exact >= lim / 2) || (exact < -(lim / 2));
      res   = full % lim;
`ifdef ADDSUB_SATURATE_EN
      if (e.ov) res = (exact > 0) ? lim / 2 - 1 : lim / 2;
`endif
      e.res = W'(res);
      e.z   = (res == 0);
      e.n   = (res >= lim / 2);
      return e;
   endfunction

   // One cycle: drive at negedge, evaluate transfers, advance to next negedge.
   task automatic step(input logic v, input logic [1:0] o, input logic [W-1:0] ai,
                       input logic [W-1:0] bi, input logic ci, input logic ordy);
      exp_t e;
      in_valid  = v;
      op        = o;
      a         = ai;
      b         = bi;
      cin       = ci;
      out_ready = ordy;
      #1;
      last_in_ready = in_ready;
      last_acc  = in_valid && in_ready;
      last_emit = out_valid && out_ready;
      if (stalled) begin
         chk("hold_valid", int'(out_valid), 1);
         chk("hold_result", int'(result), int'(held.res));
         chk("hold_flags", int'({carry_out, overflow, zero, negative}),
             int'({held.co, held.ov, held.z, held.n}));
      end
      stalled = out_valid && !out_ready;
      if (stalled) begin
         held.res = result;
         held.co  = carry_out;
         held.ov  = overflow;
         held.z   = zero;
         held.n   = negative;
      end
      if (last_emit) begin
         if (q.size() == 0) begin
            chk("spurious_beat", 1, 0);
         end else begin
            e = q.pop_front();
            chk("stream_result", int'(result), int'(e.res));
            chk("stream_flags", int'({carry_out, overflow, zero, negative}),
                int'({e.co, e.ov, e.z, e.n}));
         end
      end
      if (last_acc) q.push_back(model(o, ai, bi, ci));
      @(negedge clk);
   endtask

   task automatic step_rand(input logic v, input logic ordy);
      step(v, 2'($urandom), W'($urandom), W'($urandom), 1'($urandom), ordy);
   endtask

   initial begin
      int first_emit, n_emit, last_emit_idx;

      vecs[0] = '{2'b00, 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{2'b01, 8'h55, 8'h30, 1'b0, 8'h25, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{2'b01, 8'h30, 8'h55, 1'b0, 8'hDB, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef ADDSUB_SATURATE_EN
      vecs[3] = '{2'b00, 8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{2'b01, 8'h80, 8'h01, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1};
`else
      vecs[3] = '{2'b00, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{2'b01, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
      vecs[4] = '{2'b10, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{2'b11, 8'h10, 8'h0F, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{2'b11, 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};

      #3;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_result", int'(result), 0);
      chk("rst_flags", int'({carry_out, overflow, zero, negative}), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors with exact latency check.
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
         cin = vecs[i].cin; out_ready = 1'b1;
         #1 chk("vec_in_ready", int'(in_ready), 1);
         @(negedge clk);
         in_valid = 1'b0;
         for (int j = 0; j < S - 1; j++) begin
            #1 chk("vec_early_valid", int'(out_valid), 0);
            @(negedge clk);
         end
         #1;
         chk("vec_valid", int'(out_valid), 1);
         chk("vec_result", int'(result), int'(vecs[i].res));
         chk("vec_carry", int'(carry_out), int'(vecs[i].co));
         chk("vec_overflow", int'(overflow), int'(vecs[i].ov));
         chk("vec_zero", int'(zero), int'(vecs[i].z));
         chk("vec_negative", int'(negative), int'(vecs[i].n));
         @(negedge clk);
      end

      // 8 back-to-back beats: results must be consecutive and in order.
      first_emit = -1; n_emit = 0; last_emit_idx = -1;
      for (int i = 0; i < 8 + S + 4; i++) begin
         step_rand(i < 8, 1'b1);
         if (last_emit) begin
            if (first_emit < 0) first_emit = i;
            last_emit_idx = i;
            n_emit++;
         end
      end
      chk("stream_first_cycle", first_emit, S);
      chk("stream_count", n_emit, 8);
      chk("stream_consecutive", last_emit_idx - first_emit, 7);

      // Backpressure: 3 stalled cycles, in_ready must drop, output must hold.
      for (int i = 0; i < 4; i++) step_rand(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step_rand(1'b1, 1'b0);
         chk("stall_in_ready", int'(last_in_ready), 0);
      end
      for (int i = 0; i < S + 4; i++) step_rand(1'b0, 1'b1);
      chk("stall_drained", q.size(), 0);

      // Asynchronous reset with two beats in flight.
      step(1'b1, 2'b00, 8'h12, 8'h34, 1'b0, 1'b0);
      step(1'b1, 2'b01, 8'h56, 8'h01, 1'b0, 1'b0);
      in_valid = 1'b0;
      #1 chk("inflight_valid", int'(out_valid), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", int'(out_valid), 0);
      chk("arst_result", int'(result), 0);
      chk("arst_flags", int'({carry_out, overflow, zero, negative}), 0);
      q.delete();
      stalled = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_emit = 0;
      for (int i = 0; i < S + 4; i++) begin
         step_rand(1'b0, 1'b1);
         if (last_emit) n_emit++;
      end
      chk("no_stale_beat", n_emit, 0);

      // Random traffic with random backpressure against the arithmetic model.
      for (int i = 0; i < 400; i++)
         step_rand(1'($urandom_range(99) < 70), 1'($urandom_range(99) < 60));
      for (int i = 0; i < S + 6; i++) step_rand(1'b0, 1'b1);
      chk("random_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end
endmodule
